voice_scheduler: RTL and testbench

//  Polyphonic voice allocator and time-slot scheduler for the shared sample ROM.
//  - Takes the key bitmap from codeword_processor and assigns held keys to NUM_VOICES voices.
//  - On each sample tick, sequences one ROM read per voice.
//  - Mixes the voice samples into one 8-bit output that drives the synth output pins.

---
 rtl/voice_scheduler.sv | 167 ++++++++++++++++
 tb/tb_voice_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// voice_scheduler: polyphonic voice allocator, per-voice ROM slot sequencer and saturating mixer.
// Define VOICE_STEAL_EN to let a press with no free voice steal the oldest active voice.
module voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int PHASE_W = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   keys,
  input  logic                  sample_tick,
  output logic                  rom_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [DATA_W-1:0]     mix_out,
  output logic                  mix_valid,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  overrun
);
  localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int CW = ROM_LAT > 0 ? $clog2(ROM_LAT + 1) : 1;
  localparam int SW = DATA_W + $clog2(NUM_VOICES) + 1;
  localparam int AGE_W = 8;
  localparam logic [1:0] IDLE = 2'd0, SLOT = 2'd1, MIX = 2'd2;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif
  localparam logic signed [SW-1:0] MID = SW'(1 << (DATA_W - 1));
  localparam logic signed [SW-1:0] TOP = SW'((1 << DATA_W) - 1);

  function automatic logic [PHASE_W-1:0] inc_of(input logic [KW-1:0] k);
    int i = int'(k);
    return PHASE_W'(i == 0 ? 351 : i == 1 ? 394 : i == 2 ? 442 : i == 3 ? 469 :
                    i == 4 ? 526 : i == 5 ? 591 : i == 6 ? 663 : 702);
  endfunction

  logic [1:0]              state;
  logic [VW-1:0]           slot;
  logic [CW-1:0]           cnt;
  logic signed [SW-1:0]    acc;
  logic [NUM_KEYS-1:0]     keys_q, pend_rel, pend_prs;
  logic [NUM_VOICES-1:0]   v_act;
  logic [KW-1:0]           v_key   [NUM_VOICES];
  logic [PHASE_W-1:0]      v_phase [NUM_VOICES];
  logic [AGE_W-1:0]        v_age   [NUM_VOICES];

  logic [KW-1:0]           rel_k, prs_k, ev_k;
  logic                    ev_valid, ev_rel, hit, free_any;
  logic [VW-1:0]           hit_v, free_v, old_v, tgt_v;
  logic [NUM_KEYS-1:0]     served;
  logic                    do_clear, do_retrig, do_load;

  // One pending event per IDLE cycle: releases before presses, lowest key first
  always_comb begin
    rel_k = '0;
    prs_k = '0;
    hit = 1'b0;
    hit_v = '0;
    free_any = 1'b0;
    free_v = '0;
    old_v = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend_rel[i]) rel_k = KW'(i);
      if (pend_prs[i]) prs_k = KW'(i);
    end
    ev_rel = |pend_rel;
    ev_k = ev_rel ? rel_k : prs_k;
    ev_valid = state == IDLE && (ev_rel || |pend_prs);
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v_act[i] && v_key[i] == ev_k) begin
        hit = 1'b1;
        hit_v = VW'(i);
      end
      if (!v_act[i]) begin
        free_any = 1'b1;
        free_v = VW'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++)
      if (v_age[i] > v_age[old_v]) old_v = VW'(i);
    tgt_v = hit ? hit_v : free_any ? free_v : old_v;
    served = ev_valid ? NUM_KEYS'(1) << ev_k : '0;
    do_clear = ev_valid && ev_rel && hit;
    do_retrig = ev_valid && !ev_rel && hit;
    do_load = ev_valid && !ev_rel && !hit && (free_any || STEAL);
  end

  logic signed [SW-1:0] samp, acc_nxt, sum;
  logic [DATA_W-1:0]    clamped;
  logic                 last_cyc;

  always_comb begin
    last_cyc = cnt == CW'(ROM_LAT);
    samp = $signed(SW'(rom_data)) - MID;
    acc_nxt = v_act[slot] ? acc + samp : acc;
    sum = acc_nxt + MID;
    clamped = sum < 0 ? '0 : sum > TOP ? '1 : DATA_W'(sum);
  end

  assign rom_en = state == SLOT && cnt == '0;
  assign rom_addr = rom_en ? v_phase[slot][PHASE_W-1 -: ADDR_W] : '0;
  assign mix_valid = state == MIX;
  assign voice_active = v_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot <= '0;
      cnt <= '0;
      acc <= '0;
      keys_q <= '0;
      pend_rel <= '0;
      pend_prs <= '0;
      v_act <= '0;
      mix_out <= DATA_W'(1 << (DATA_W - 1));
      overrun <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_key[i] <= '0;
        v_phase[i] <= '0;
        v_age[i] <= '0;
      end
    end else begin
      keys_q <= keys;
      pend_rel <= (pend_rel & ~(ev_rel ? served : '0)) | (~keys & keys_q);
      pend_prs <= (pend_prs & ~(ev_rel ? '0 : served)) | (keys & ~keys_q);
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      if (do_clear) v_act[tgt_v] <= 1'b0;
      if (do_retrig) v_phase[tgt_v] <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (do_load && VW'(i) == tgt_v) begin
          v_act[i] <= 1'b1;
          v_key[i] <= ev_k;
          v_phase[i] <= '0;
          v_age[i] <= '0;
        end else if (do_load && v_act[i] && v_age[i] != '1) begin
          v_age[i] <= v_age[i] + 1'b1;
        end
        if (state == MIX && v_act[i]) v_phase[i] <= v_phase[i] + inc_of(v_key[i]);
      end
      if (state == IDLE && sample_tick) begin
        state <= SLOT;
        slot <= '0;
        cnt <= '0;
        acc <= '0;
      end
      // Every voice gets a fixed ROM_LAT+1 cycle slot so frame timing never depends on activity
      if (state == SLOT) begin
        cnt <= last_cyc ? '0 : cnt + 1'b1;
        if (last_cyc) begin
          acc <= acc_nxt;
          slot <= slot + 1'b1;
          if (slot == VW'(NUM_VOICES - 1)) begin
            state <= MIX;
            mix_out <= clamped;
          end
        end
      end
      if (state == MIX) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: randomized key/tick stimulus checked every cycle against a frame-level voice model.
module tb_voice_scheduler;
  localparam int NV = 4;
  localparam int FR = NV * 2 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_tick = 1'b0;
  logic [7:0] keys = 8'h00;
  logic [7:0] rom_data = 8'h00;
  logic rom_en, mix_valid, overrun;
  logic [7:0] rom_addr, mix_out;
  logic [NV-1:0] voice_active;
  logic [7:0] rom [256];
  int vectors = 0;
  int miscompares = 0;

  voice_scheduler dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .sample_tick(sample_tick),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .mix_out(mix_out), .mix_valid(mix_valid), .voice_active(voice_active),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: voice table plus a frame cycle counter (0 = idle, FR = mix cycle)
  int m_t, m_mix, m_exp;
  bit m_act [NV];
  int m_key [NV], m_phase [NV], m_age [NV];
  logic [7:0] m_kq, m_prel, m_pprs;
  bit m_ovr;
  int inc_tab [8] = '{351, 394, 442, 469, 526, 591, 663, 702};

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int mix_now();
    int s = 128;
    for (int v = 0; v < NV; v++) if (m_act[v]) s += int'(rom[m_phase[v] >> 8]) - 128;
    return s < 0 ? 0 : s > 255 ? 255 : s;
  endfunction

  function automatic void m_press(input int k);
    int f = -1;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && m_key[v] == k) begin
        m_phase[v] = 0;
        return;
      end
    for (int v = 0; v < NV; v++) if (!m_act[v] && f < 0) f = v;
    if (f < 0) begin
`ifdef VOICE_STEAL_EN
      f = 0;
      for (int v = 1; v < NV; v++) if (m_age[v] > m_age[f]) f = v;
`else
      return;
`endif
    end
    for (int v = 0; v < NV; v++) if (v != f && m_act[v] && m_age[v] < 255) m_age[v]++;
    m_act[f] = 1;
    m_key[f] = k;
    m_phase[f] = 0;
    m_age[f] = 0;
  endfunction

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      m_t = 0; m_mix = 8'h80; m_exp = 0; m_ovr = 0;
      m_kq = 0; m_prel = 0; m_pprs = 0;
      for (int v = 0; v < NV; v++) begin
        m_act[v] = 0; m_key[v] = 0; m_phase[v] = 0; m_age[v] = 0;
      end
    end else begin
      if (m_t == 0) begin
        if (m_prel != 0) begin
          k = lowest(m_prel);
          m_prel[k] = 1'b0;
          for (int v = 0; v < NV; v++) if (m_act[v] && m_key[v] == k) m_act[v] = 0;
        end else if (m_pprs != 0) begin
          k = lowest(m_pprs);
          m_pprs[k] = 1'b0;
          m_press(k);
        end
      end
      m_prel |= ~keys & m_kq;
      m_pprs |= keys & ~m_kq;
      m_kq = keys;
      if (m_t == 0) begin
        if (sample_tick) begin
          m_t = 1;
          m_exp = mix_now();
        end
      end else begin
        if (sample_tick) m_ovr = 1;
        if (m_t == FR) begin
          for (int v = 0; v < NV; v++)
            if (m_act[v]) m_phase[v] = (m_phase[v] + (m_key[v] < 8 ? inc_tab[m_key[v]] : 702)) & 16'hFFFF;
          m_t = 0;
        end else begin
          m_t++;
          if (m_t == FR) m_mix = m_exp;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NV-1:0] va;
    bit en;
    int addr;
    if (rst_n) begin
      for (int v = 0; v < NV; v++) va[v] = m_act[v];
      en = m_t >= 1 && m_t < FR && (m_t - 1) % 2 == 0;
      addr = en ? (m_phase[(m_t - 1) / 2] >> 8) : 0;
      check("voice_active", 32'(voice_active), 32'(va));
      check("rom_en", 32'(rom_en), 32'(en));
      check("rom_addr", 32'(rom_addr), addr);
      check("mix_valid", 32'(mix_valid), 32'(m_t == FR));
      check("mix_out", 32'(mix_out), m_mix);
      check("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic run_frame(output int lat, output logic [7:0] a0, input int chg_n, input logic [7:0] chg_keys);
    lat = 0;
    a0 = 0;
    @(negedge clk) sample_tick = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk) sample_tick = 1'b0;
      if (n == chg_n) keys = chg_keys;
      if (n == 1) a0 = rom_addr;
      if (mix_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, pulses;
    logic [7:0] a0;
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    repeat (3) @(negedge clk);
    check("rst_mix_out", 32'(mix_out), 32'h80);
    check("rst_voice_active", 32'(voice_active), 0);
    check("rst_mix_valid", 32'(mix_valid), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    keys = 8'h01;
    repeat (3) @(negedge clk);
    check("one_voice_active", 32'(voice_active), 32'b0001);
    run_frame(lat, a0, 0, 0);
    check("latency", lat, 9);
    check("one_voice_mix", 32'(mix_out), 32'hC0);
    run_frame(lat, a0, 0, 0);
    check("phase_after_mix", 32'(a0), 32'h01);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_mix_out", 32'(mix_out), 32'h80);
    check("midrst_mix_valid", 32'(mix_valid), 0);
    check("midrst_voice_active", 32'(voice_active), 0);
    check("midrst_rom_en", 32'(rom_en), 0);
    keys = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
    keys = 8'h0F;
    repeat (6) @(negedge clk);
    check("four_voices", 32'(voice_active), 32'hF);
    run_frame(lat, a0, 0, 0);
    check("sat_high", 32'(mix_out), 32'hFF);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    run_frame(lat, a0, 0, 0);
    check("sat_low", 32'(mix_out), 32'h00);
    keys = 8'h1F;
    repeat (3) @(negedge clk);
    check("full_press", 32'(voice_active), 32'hF);
    keys = 8'h0F;
    repeat (3) @(negedge clk);
`ifdef VOICE_STEAL_EN
    check("steal_release", 32'(voice_active), 32'b1110);
`else
    check("nosteal_release", 32'(voice_active), 32'b1111);
`endif
    keys = 8'h00;
    repeat (6) @(negedge clk);
    check("overrun_before", 32'(overrun), 0);
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    @(negedge clk) sample_tick = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk) sample_tick = (n == 3);
      if (mix_valid) pulses++;
    end
    check("overrun_pulses", pulses, 1);
    check("overrun_flag", 32'(overrun), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    keys = 8'h01;
    repeat (3) @(negedge clk);
    check("rel_before", 32'(voice_active), 32'b0001);
    run_frame(lat, a0, 2, 8'h00);
    check("rel_frame_mix", 32'(mix_out), 32'hC0);
    repeat (3) @(negedge clk);
    check("rel_after", 32'(voice_active), 0);
    run_frame(lat, a0, 0, 0);
    check("rel_next_mix", 32'(mix_out), 32'h80);
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) keys = 8'($urandom);
      sample_tick = $urandom_range(0, 9) == 0;
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
    end
    @(negedge clk) sample_tick = 1'b0;
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
